at_cmd_sequencer: RTL

Sequences a fixed list of AT command strings out through the UART transmitter, then waits for the "OK\r\n" detector flag from the UART receive path before moving on. Handles per-command response timeout, bounded retries and an inter-command gap. Sits between the system start/status logic and the UART TX/RX pair in the UART_Server subsystem. Command strings are read from an external synchronous ROM.

---
 rtl/at_cmd_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/at_cmd_sequencer.sv
// AT command sequencer: streams ROM-held command strings to the UART
// transmitter and waits for the OK flag, with timeout, retry and gap.
module at_cmd_sequencer #(
  parameter int N_CMDS      = 4,
  parameter int CMD_AW      = 2,
  parameter int BYTE_AW     = 5,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int MAX_RETRY   = 3,
  parameter int GAP_CYC     = 1000,
  parameter int CNT_W       = 26
) (
  input  logic                      iCLK,
  input  logic                      RST_n,
  input  logic                      start,
  output logic [CMD_AW+BYTE_AW-1:0] rom_addr,
  input  logic [7:0]                rom_data,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_done,
  output logic                      receive_ok_en,
  input  logic                      receiver_OK,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [CMD_AW-1:0]         err_cmd
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CMD_AW-1:0] CMD_LAST = CMD_AW'(N_CMDS - 1);
  localparam logic [RW-1:0]     RTY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, GAP, FETCH, LOAD, WAIT_TX, WAIT_OK, DONE, FAIL
  } state_t;

  state_t              state;
  logic [CMD_AW-1:0]   cmd_idx;
  logic [BYTE_AW-1:0]  byte_idx;
  logic [RW-1:0]       retry_cnt;
  logic [CNT_W-1:0]    cnt;
  logic [RW-1:0]       retry_nxt;

  assign retry_nxt = retry_cnt + 1'b1;

  // Indices are registers, so the ROM sees a stable address during FETCH.
  assign rom_addr = {cmd_idx, byte_idx};

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      state         <= IDLE;
      cmd_idx       <= '0;
      byte_idx      <= '0;
      retry_cnt     <= '0;
      cnt           <= '0;
      tx_start      <= 1'b0;
      tx_data       <= 8'h00;
      receive_ok_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_cmd       <= '0;
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cmd_idx   <= '0;
            retry_cnt <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            byte_idx <= '0;
            state    <= FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          if (rom_data == 8'h00) begin
            cnt           <= '0;
            receive_ok_en <= 1'b1;
            state         <= WAIT_OK;
          end else begin
            tx_data  <= rom_data;
            tx_start <= 1'b1;
            state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
            if (byte_idx == '1) begin
              cnt           <= '0;
              receive_ok_en <= 1'b1;
              state         <= WAIT_OK;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= FETCH;
            end
          end
        end
        WAIT_OK: begin
          cnt <= cnt + 1'b1;
          // OK takes priority over a timeout landing in the same cycle.
          if (receiver_OK) begin
            receive_ok_en <= 1'b0;
            retry_cnt     <= '0;
            cnt           <= '0;
            if (cmd_idx == CMD_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              cmd_idx <= cmd_idx + 1'b1;
              state   <= GAP;
            end
          end else if (cnt == TO_LAST) begin
            receive_ok_en <= 1'b0;
            cnt           <= '0;
            retry_cnt     <= retry_nxt;
            if (retry_nxt == RTY_MAX) begin
              error   <= 1'b1;
              err_cmd <= cmd_idx;
              busy    <= 1'b0;
              state   <= FAIL;
            end else begin
              state <= GAP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
